// File: rtl/wash_sequencer_pkg.sv
// Shared encodings and elaboration helpers for the washing-machine sequencer.
package wm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_SPIN  = 3'd3,
    PH_DONE  = 3'd4
  } phase_e;

  localparam logic [1:0] MODE_DRY    = 2'd0;
  localparam logic [1:0] MODE_SMALL  = 2'd1;
  localparam logic [1:0] MODE_MEDIUM = 2'd2;
  localparam logic [1:0] MODE_BIG    = 2'd3;

  localparam logic [11:0] BCD_MAX = 12'h999;

  // Integer to 3-digit BCD, clamped to 999; used for parameter durations.
  function automatic logic [11:0] int_to_bcd3(input int v);
    int c;
    c = (v > 999) ? 999 : ((v < 0) ? 0 : v);
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Customer/admin signal bundle of the wash sequencer.
interface wash_sequencer_if;

  logic        start;
  logic [1:0]  mode;
  logic        pause;
  logic        pickup;
  logic [11:0] dy_price;
  logic [11:0] s_price;
  logic [11:0] m_price;
  logic [11:0] b_price;
  logic [11:0] setfine;
  logic [2:0]  phase;
  logic [11:0] remain;
  logic [11:0] charge;
  logic [11:0] profit;
  logic [11:0] runtime;
  logic        busy;
  logic        done_alarm;

  modport master (
    output start, mode, pause, pickup, dy_price, s_price, m_price, b_price, setfine,
    input  phase, remain, charge, profit, runtime, busy, done_alarm
  );

  modport slave (
    input  start, mode, pause, pickup, dy_price, s_price, m_price, b_price, setfine,
    output phase, remain, charge, profit, runtime, busy, done_alarm
  );

endinterface

// File: rtl/wash_sequencer_bcd3_add_sat.sv
// Combinational 3-digit BCD adder; any sum above 999 saturates to 999.
module bcd3_add_sat
  import wm_pkg::*;
(
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] sum_o
);

  logic [11:0] raw;
  logic        carry;
  logic [4:0]  dig;

  always_comb begin
    raw   = '0;
    carry = 1'b0;
    dig   = '0;
    for (int i = 0; i < 3; i++) begin
      dig = {1'b0, a_i[i*4 +: 4]} + {1'b0, b_i[i*4 +: 4]} + {4'b0000, carry};
      // Decimal adjust: skip the six unused nibble codes.
      if (dig > 5'd9) begin
        dig   = dig + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[i*4 +: 4] = dig[3:0];
    end
    sum_o = carry ? BCD_MAX : raw;
  end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine run-time controller: pricing, phase timing, overtime fine,
// profit and run-time accounting, all in 3-digit BCD.
module wash_sequencer
  import wm_pkg::*;
#(
  parameter int TICK_DIV       = 100000000,
  parameter int WASH_T_S       = 4,
  parameter int WASH_T_M       = 6,
  parameter int WASH_T_B       = 8,
  parameter int RINSE_T        = 3,
  parameter int SPIN_T         = 2,
  parameter int DRY_T          = 3,
  parameter int OVERTIME_LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  wash_sequencer_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [11:0] WASH_S_B = int_to_bcd3(WASH_T_S);
  localparam logic [11:0] WASH_M_B = int_to_bcd3(WASH_T_M);
  localparam logic [11:0] WASH_B_B = int_to_bcd3(WASH_T_B);
  localparam logic [11:0] RINSE_B  = int_to_bcd3(RINSE_T);
  localparam logic [11:0] SPIN_B   = int_to_bcd3(SPIN_T);
  localparam logic [11:0] DRY_B    = int_to_bcd3(DRY_T);
  localparam logic [11:0] OVER_B   = int_to_bcd3(OVERTIME_LIMIT);

  phase_e           phase_q, phase_d;
  logic [11:0]      remain_q, remain_d;
  logic [11:0]      charge_q, charge_d;
  logic [11:0]      profit_q, profit_d;
  logic [11:0]      runtime_q, runtime_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tick, start_ok;
  logic [11:0]      price_sel, wash_sel;
  logic [11:0]      fine_sum, profit_sum, runtime_inc;

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  assign start_ok = bus.start && (phase_q == PH_IDLE);
  assign tick     = (cnt_q == CNT_LAST) && !bus.pause;

  // Prescaler restarts on an accepted start so the first second is a full one.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)                cnt_d = '0;
    else if (!bus.pause)         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    price_sel = bus.dy_price;
    wash_sel  = DRY_B;
    case (bus.mode)
      MODE_SMALL:  begin price_sel = bus.s_price; wash_sel = WASH_S_B; end
      MODE_MEDIUM: begin price_sel = bus.m_price; wash_sel = WASH_M_B; end
      MODE_BIG:    begin price_sel = bus.b_price; wash_sel = WASH_B_B; end
      default:     begin price_sel = bus.dy_price; wash_sel = DRY_B; end
    endcase
  end

  bcd3_add_sat u_fine    (.a_i(charge_q),  .b_i(bus.setfine), .sum_o(fine_sum));
  bcd3_add_sat u_profit  (.a_i(profit_q),  .b_i(charge_q),    .sum_o(profit_sum));
  bcd3_add_sat u_runtime (.a_i(runtime_q), .b_i(12'h001),     .sum_o(runtime_inc));

  always_comb begin
    phase_d   = phase_q;
    remain_d  = remain_q;
    charge_d  = charge_q;
    profit_d  = profit_q;
    runtime_d = runtime_q;
    case (phase_q)
      PH_IDLE: begin
        if (bus.start) begin
          charge_d = price_sel;
          remain_d = wash_sel;
          phase_d  = (bus.mode == MODE_DRY) ? PH_SPIN : PH_WASH;
        end
      end
      PH_WASH, PH_RINSE, PH_SPIN: begin
        if (tick) begin
          runtime_d = runtime_inc;
          if (remain_q == 12'h001) begin
            if (phase_q == PH_WASH) begin
              phase_d  = PH_RINSE;
              remain_d = RINSE_B;
            end else if (phase_q == PH_RINSE) begin
              phase_d  = PH_SPIN;
              remain_d = SPIN_B;
            end else begin
              phase_d  = PH_DONE;
              remain_d = OVER_B;
            end
          end else begin
            remain_d = bcd_dec(remain_q);
          end
        end
      end
      PH_DONE: begin
        // Pickup takes priority over a coincident tick, so no fine is added.
        if (bus.pickup) begin
          profit_d = profit_sum;
          phase_d  = PH_IDLE;
          remain_d = '0;
        end else if (tick) begin
          if (remain_q != 12'h000) remain_d = bcd_dec(remain_q);
          else                     charge_d = fine_sum;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      remain_q  <= '0;
      charge_q  <= '0;
      profit_q  <= '0;
      runtime_q <= '0;
      cnt_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      remain_q  <= remain_d;
      charge_q  <= charge_d;
      profit_q  <= profit_d;
      runtime_q <= runtime_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.remain     = remain_q;
  assign bus.charge     = charge_q;
  assign bus.profit     = profit_q;
  assign bus.runtime    = runtime_q;
  assign bus.busy       = (phase_q != PH_IDLE);
  assign bus.done_alarm = (phase_q == PH_DONE);

endmodule
